register_file_core: RTL

Storage side of the Frost32 register-file port bundle: consumes the read-select/write port group and produces the five read-data words. Holds 16 × 32-bit general registers with r0 hardwired to zero. Adds a pending-write scoreboard that tells decode when an operand is still in flight, so the pipeline can stall on hazards. Sits between decode (read selects, reservations) and writeback (write port).

---
 rtl/register_file_core.sv | 104 ++++++++++
 1 files changed

// File: rtl/register_file_core.sv
// Frost32 register file: 16x32 storage (r0 reads zero), five combinational read ports, pending-write scoreboard.
// Latency: writes and reservations take effect at the next clk edge; reads and hazard are combinational.
// Backpressure: none, strobes accepted every cycle. Optional `REG_FILE_BYPASS_EN adds same-cycle write-through.
module register_file_core #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    localparam int SEL_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_WIDTH-1:0]  read_sel_ra,
    input  logic [SEL_WIDTH-1:0]  read_sel_rb,
    input  logic [SEL_WIDTH-1:0]  read_sel_rc,
    input  logic [SEL_WIDTH-1:0]  read_sel_cond_ra,
    input  logic [SEL_WIDTH-1:0]  read_sel_cond_rb,
    input  logic [SEL_WIDTH-1:0]  write_sel,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic                  reserve_en,
    input  logic [SEL_WIDTH-1:0]  reserve_sel,
    output logic [DATA_WIDTH-1:0] read_data_ra,
    output logic [DATA_WIDTH-1:0] read_data_rb,
    output logic [DATA_WIDTH-1:0] read_data_rc,
    output logic [DATA_WIDTH-1:0] read_data_cond_ra,
    output logic [DATA_WIDTH-1:0] read_data_cond_rb,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  hazard
);

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;
    logic                  wr_hit;
    logic                  rsv_hit;
    logic [SEL_WIDTH-1:0]  sel   [5];
    logic [DATA_WIDTH-1:0] rdata [5];
    logic [4:0]            hit;

    assign wr_hit  = write_en   && (write_sel   != '0);
    assign rsv_hit = reserve_en && (reserve_sel != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[write_sel] <= write_data;
        end
    end

    // Reservation is applied after the clear so a younger reserve wins over a same-cycle write.
    always_comb begin
        pending_nxt = pending;
        if (wr_hit) begin
            pending_nxt[write_sel] = 1'b0;
        end
        if (rsv_hit) begin
            pending_nxt[reserve_sel] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign sel[0] = read_sel_ra;
    assign sel[1] = read_sel_rb;
    assign sel[2] = read_sel_rc;
    assign sel[3] = read_sel_cond_ra;
    assign sel[4] = read_sel_cond_rb;

    always_comb begin
        for (int p = 0; p < 5; p++) begin
            rdata[p] = '0;
            hit[p]   = 1'b0;
            if (sel[p] != '0) begin
                rdata[p] = regs[sel[p]];
                hit[p]   = pending[sel[p]];
`ifdef REG_FILE_BYPASS_EN
                // Data arriving this cycle is forwarded, so the operand is no longer a hazard.
                if (wr_hit && (sel[p] == write_sel)) begin
                    rdata[p] = write_data;
                    hit[p]   = 1'b0;
                end
`endif
            end
        end
    end

    assign read_data_ra      = rdata[0];
    assign read_data_rb      = rdata[1];
    assign read_data_rc      = rdata[2];
    assign read_data_cond_ra = rdata[3];
    assign read_data_cond_rb = rdata[4];
    assign pending_mask      = pending;
    assign hazard            = |hit;

endmodule
